// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset core: opcodes, ALU ops,
// FSM states, immediate kinds and the instruction decoder.
package cpu_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_LSW = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_J    = 3'd4;

    typedef struct packed {
        logic       legal;
        logic [2:0] alu_op;
        logic       use_imm;
        logic [2:0] imm_kind;
        logic       is_lw;
        logic       is_sw;
        logic       is_br;
        logic       is_jal;
        logic       writes_rd;
        logic       uses_rs1;
        logic       uses_rs2;
    } ctrl_t;

    function automatic logic [31:0] make_imm(input logic [31:0] ir, input logic [2:0] kind);
        case (kind)
            IMM_I:   return {{20{ir[31]}}, ir[31:20]};
            IMM_S:   return {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_J:   return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: return 32'd0;
        endcase
    endfunction

    function automatic ctrl_t decode(input logic [31:0] ir);
        ctrl_t      c;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ir[14:12];
        f7 = ir[31:25];
        c = '0;
        c.alu_op = ALU_ADD;
        c.imm_kind = IMM_NONE;
        case (ir[6:0])
            OP_R: begin
                c.writes_rd = 1'b1;
                c.uses_rs1 = 1'b1;
                c.uses_rs2 = 1'b1;
                c.legal = 1'b1;
                if (f7 == F7_SUB && f3 == F3_ADD) c.alu_op = ALU_SUB;
                else if (f7 == F7_BASE && f3 == F3_ADD) c.alu_op = ALU_ADD;
                else if (f7 == F7_BASE && f3 == F3_SLT) c.alu_op = ALU_SLT;
                else if (f7 == F7_BASE && f3 == F3_OR)  c.alu_op = ALU_OR;
                else if (f7 == F7_BASE && f3 == F3_AND) c.alu_op = ALU_AND;
                else c.legal = 1'b0;
            end
            OP_ADDI: begin
                c.legal = (f3 == F3_ADD);
                c.use_imm = 1'b1;
                c.imm_kind = IMM_I;
                c.writes_rd = 1'b1;
                c.uses_rs1 = 1'b1;
            end
            OP_LW: begin
                c.legal = (f3 == F3_LSW);
                c.is_lw = 1'b1;
                c.use_imm = 1'b1;
                c.imm_kind = IMM_I;
                c.writes_rd = 1'b1;
                c.uses_rs1 = 1'b1;
            end
            OP_SW: begin
                c.legal = (f3 == F3_LSW);
                c.is_sw = 1'b1;
                c.use_imm = 1'b1;
                c.imm_kind = IMM_S;
                c.uses_rs1 = 1'b1;
                c.uses_rs2 = 1'b1;
            end
            OP_BR: begin
                c.legal = (f3 == F3_BEQ) || (f3 == F3_BNE);
                c.is_br = 1'b1;
                c.imm_kind = IMM_B;
                c.uses_rs1 = 1'b1;
                c.uses_rs2 = 1'b1;
            end
            OP_JAL: begin
                c.legal = 1'b1;
                c.is_jal = 1'b1;
                c.imm_kind = IMM_J;
                c.writes_rd = 1'b1;
            end
            default: c.legal = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu.sv
// 32-bit ALU shared with the single-cycle core; op codes come from cpu_pkg.
module alu
    import cpu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    always_comb begin
        case (op)
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SLT: y = {31'd0, $signed(a) < $signed(b)};
            default: y = a + b;
        endcase
    end

endmodule

// File: rtl/cpu_mc_regfile.sv
// NREGS-deep register file: two async read ports, one sync write port, x0 reads 0.
module cpu_mc_regfile #(
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic [31:0]   rdata1,
    output logic [31:0]   rdata2,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata
);

    logic [31:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? 32'd0 : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? 32'd0 : regs[raddr2];

endmodule

// File: rtl/cpu_mc.sv
// Multi-cycle RV32I-subset core with one unified req/ready memory port.
// Optional CPU_PERF_CNT_EN adds 64-bit cycle and retired-instruction counters.
module cpu_mc
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc_o,
    output logic        instr_retired,
    output logic        halted
`ifdef CPU_PERF_CNT_EN
    ,
    output logic [63:0] perf_cycle,
    output logic [63:0] perf_instret
`endif
);

    localparam int         AW      = $clog2(NREGS);
    localparam logic [5:0] NREGS_L = 6'(NREGS);

    logic [2:0]  state;
    logic [31:0] pc, ir, a_reg, b_reg, imm, alu_out, mdr;
    logic [31:0] rs1_val, rs2_val, alu_b, alu_y, target, pc_plus4, wb_data;
    logic        reg_ok, taken, br_bad, jal_bad, data_bad, rf_we;
    ctrl_t       ctrl;

    assign ctrl     = decode(ir);
    assign alu_b    = ctrl.use_imm ? imm : b_reg;
    assign pc_plus4 = pc + 32'd4;
    assign target   = pc + imm;
    assign taken    = ctrl.is_br && ((a_reg == b_reg) ^ ir[12]);
    assign br_bad   = taken && (target[1:0] != 2'b00);
    assign jal_bad  = ctrl.is_jal && (target[1:0] != 2'b00);
    assign data_bad = (alu_out[1:0] != 2'b00);
    assign wb_data  = ctrl.is_lw ? mdr : (ctrl.is_jal ? pc_plus4 : alu_out);
    assign rf_we    = (state == S_WB) && ctrl.writes_rd;

    // Only register fields the instruction actually uses are range-checked (RV32E).
    assign reg_ok = !((ctrl.uses_rs1  && {1'b0, ir[19:15]} >= NREGS_L) ||
                      (ctrl.uses_rs2  && {1'b0, ir[24:20]} >= NREGS_L) ||
                      (ctrl.writes_rd && {1'b0, ir[11:7]}  >= NREGS_L));

    cpu_mc_regfile #(.NREGS(NREGS), .AW(AW)) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (ir[15 +: AW]),
        .raddr2 (ir[20 +: AW]),
        .rdata1 (rs1_val),
        .rdata2 (rs2_val),
        .we     (rf_we),
        .waddr  (ir[7 +: AW]),
        .wdata  (wb_data)
    );

    alu u_alu (
        .op (ctrl.alu_op),
        .a  (a_reg),
        .b  (alu_b),
        .y  (alu_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            ir      <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            imm     <= '0;
            alu_out <= '0;
            mdr     <= '0;
        end else begin
            case (state)
                S_FETCH: if (mem_ready) begin
                    ir    <= mem_rdata;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    a_reg <= rs1_val;
                    b_reg <= rs2_val;
                    imm   <= make_imm(ir, ctrl.imm_kind);
                    state <= (ctrl.legal && reg_ok) ? S_EXEC : S_HALT;
                end
                S_EXEC: begin
                    alu_out <= alu_y;
                    if (ctrl.is_br) begin
                        if (br_bad) state <= S_HALT;
                        else begin
                            pc    <= taken ? target : pc_plus4;
                            state <= S_FETCH;
                        end
                    end else if (jal_bad) state <= S_HALT;
                    else if (ctrl.is_lw || ctrl.is_sw) state <= S_MEM;
                    else state <= S_WB;
                end
                S_MEM: begin
                    if (data_bad) state <= S_HALT;
                    else if (mem_ready) begin
                        if (ctrl.is_lw) begin
                            mdr   <= mem_rdata;
                            state <= S_WB;
                        end else begin
                            pc    <= pc_plus4;
                            state <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    pc    <= ctrl.is_jal ? target : pc_plus4;
                    state <= S_FETCH;
                end
                default: state <= S_HALT;
            endcase
        end
    end

    // Request fields are pure functions of held registers, so they stay stable while waiting.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc;
        mem_wdata = b_reg;
        if (!rst) begin
            if (state == S_FETCH) mem_req = 1'b1;
            else if (state == S_MEM) begin
                mem_req  = !data_bad;
                mem_we   = ctrl.is_sw;
                mem_addr = alu_out;
            end
        end
    end

    assign instr_retired = !rst && ((state == S_WB) ||
                                    (state == S_EXEC && ctrl.is_br && !br_bad) ||
                                    (state == S_MEM && ctrl.is_sw && !data_bad && mem_ready));
    assign halted = (state == S_HALT);
    assign pc_o   = pc;

`ifdef CPU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycle   <= '0;
            perf_instret <= '0;
        end else begin
            perf_cycle <= perf_cycle + 64'd1;
            if (instr_retired) perf_instret <= perf_instret + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_mc.sv
// Bench for cpu_mc: wait-state memory model, instruction-set reference model and
// a transaction/retire scoreboard checked by an independent monitor.
module tb_cpu_mc;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          MW       = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ready, instr_retired, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_o;
`ifdef CPU_PERF_CNT_EN
    logic [63:0] perf_cycle, perf_instret;
`endif

    cpu_mc #(.RESET_PC(RESET_PC), .NREGS(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .pc_o          (pc_o),
        .instr_retired (instr_retired),
        .halted        (halted)
`ifdef CPU_PERF_CNT_EN
        ,
        .perf_cycle    (perf_cycle),
        .perf_instret  (perf_instret)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] mem     [MW];
    logic [31:0] ref_mem [MW];
    logic [64:0] exp_q [$];   // {we, addr, wdata}
    logic [39:0] ret_q [$];   // {base cycles, pc}
    int checks = 0;
    int errors = 0;
    int fw_min = 0, fw_max = 0, dw_min = 0, dw_max = 0;

    // ---------------- memory model ----------------
    logic pending = 1'b0;
    int   wleft = 0;

    initial begin
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
    end

    always @(negedge clk) begin
        if (rst) begin
            pending = 1'b0;
            mem_ready = 1'b0;
        end else if (mem_req) begin
            if (!pending) begin
                pending = 1'b1;
                wleft = (mem_addr >= 32'h100) ? $urandom_range(dw_max, dw_min)
                                              : $urandom_range(fw_max, fw_min);
            end
            if (wleft == 0) begin
                mem_ready = 1'b1;
                pending = 1'b0;
                if (mem_we) mem[mem_addr[8:2]] = mem_wdata;
                else mem_rdata = mem[mem_addr[8:2]];
            end else begin
                wleft--;
                mem_ready = 1'b0;
                mem_rdata = $urandom;
            end
        end else begin
            pending = 1'b0;
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int          cyc = 0, last_ret = 0, stalls = 0;
    logic        held = 1'b0;
    logic [64:0] held_v;

    always @(negedge clk) begin
        logic [64:0] e;
        logic [39:0] r;
        #2;
        if (rst) begin
            cyc = 0;
            last_ret = 0;
            stalls = 0;
            held = 1'b0;
        end else begin
            cyc++;
            if (held) begin
                checks++;
                if (!(mem_req && {mem_we, mem_addr, mem_wdata} == held_v)) begin
                    errors++;
                    $display("FAIL hold cyc=%0d got req=%0b %h wanted held %h", cyc, mem_req,
                             {mem_we, mem_addr, mem_wdata}, held_v);
                end
            end
            if (mem_req && mem_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL txn_extra got we=%0b addr=%h expected none", mem_we, mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (mem_we != e[64] || mem_addr != e[63:32] || (e[64] && mem_wdata != e[31:0])) begin
                        errors++;
                        $display("FAIL txn got we=%0b addr=%h wdata=%h expected we=%0b addr=%h wdata=%h",
                                 mem_we, mem_addr, mem_wdata, e[64], e[63:32], e[31:0]);
                    end
                end
            end
            if (mem_req && !mem_ready) stalls++;
            held = mem_req && !mem_ready;
            held_v = {mem_we, mem_addr, mem_wdata};
            if (instr_retired) begin
                checks++;
                if (ret_q.size() == 0) begin
                    errors++;
                    $display("FAIL retire_extra got pc=%h expected none", pc_o);
                end else begin
                    r = ret_q.pop_front();
                    if (pc_o != r[31:0] || (cyc - last_ret) != int'(r[39:32]) + stalls) begin
                        errors++;
                        $display("FAIL retire got pc=%h cycles=%0d expected pc=%h cycles=%0d",
                                 pc_o, cyc - last_ret, r[31:0], int'(r[39:32]) + stalls);
                    end
                end
                last_ret = cyc;
                stalls = 0;
            end
        end
    end

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2, rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2, rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, rs1, input logic [31:0] imm);
        return enc_i(imm, rs1, 3'b000, rd, 7'h13);
    endfunction
    function automatic logic [31:0] lw(input logic [4:0] rd, input logic [31:0] off);
        return enc_i(off, 5'd0, 3'b010, rd, 7'h03);
    endfunction

    // ---------------- reference model ----------------
    task automatic iss();
        logic [31:0] r [32];
        logic [31:0] pc, ir, a, b, ea, tgt, nxt, ii, is, ib, ij;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7, op;
        logic        stop;
        int          base;
        for (int i = 0; i < MW; i++) ref_mem[i] = mem[i];
        for (int i = 0; i < 32; i++) r[i] = 32'd0;
        pc = RESET_PC;
        stop = 1'b0;
        for (int s = 0; s < 400 && !stop; s++) begin
            exp_q.push_back({1'b0, pc, 32'd0});
            ir = ref_mem[pc[8:2]];
            {f7, rs2, rs1, f3, rd, op} = ir;
            a = r[rs1];
            b = r[rs2];
            ii = {{20{ir[31]}}, ir[31:20]};
            is = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            ib = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            ij = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            nxt = pc + 32'd4;
            base = 4;
            if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd0) r[rd] = a + b;
            else if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd0) r[rd] = a - b;
            else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd7) r[rd] = a & b;
            else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd6) r[rd] = a | b;
            else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd2) r[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            else if (op == 7'h13 && f3 == 3'd0) r[rd] = a + ii;
            else if (op == 7'h03 && f3 == 3'd2) begin
                ea = a + ii;
                if (ea[1:0] != 2'b00) stop = 1'b1;
                else begin
                    exp_q.push_back({1'b0, ea, 32'd0});
                    r[rd] = ref_mem[ea[8:2]];
                    base = 5;
                end
            end else if (op == 7'h23 && f3 == 3'd2) begin
                ea = a + is;
                if (ea[1:0] != 2'b00) stop = 1'b1;
                else begin
                    exp_q.push_back({1'b1, ea, b});
                    ref_mem[ea[8:2]] = b;
                end
            end else if (op == 7'h63 && (f3 == 3'd0 || f3 == 3'd1)) begin
                base = 3;
                if ((a == b) != f3[0]) begin
                    tgt = pc + ib;
                    if (tgt[1:0] != 2'b00) stop = 1'b1;
                    else nxt = tgt;
                end
            end else if (op == 7'h6f) begin
                tgt = pc + ij;
                if (tgt[1:0] != 2'b00) stop = 1'b1;
                else begin
                    r[rd] = pc + 32'd4;
                    nxt = tgt;
                end
            end else stop = 1'b1;
            r[0] = 32'd0;
            if (!stop) begin
                ret_q.push_back({8'(base), pc});
                pc = nxt;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_mem(input bit rand_data);
        for (int i = 0; i < MW; i++) mem[i] = (rand_data && i >= 64) ? $urandom : 32'd0;
    endtask

    task automatic put(input logic [31:0] addr, input logic [31:0] w);
        mem[addr[8:2]] = w;
    endtask

    task automatic set_waits(input int fmin, fmax, dmin, dmax);
        fw_min = fmin; fw_max = fmax; dw_min = dmin; dw_max = dmax;
    endtask

    task automatic assert_reset(input int n);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        checks++;
        if (mem_req || instr_retired || halted || pc_o != RESET_PC) begin
            errors++;
            $display("FAIL reset got req=%0b ret=%0b halted=%0b pc=%h expected 0 0 0 %h",
                     mem_req, instr_retired, halted, pc_o, RESET_PC);
        end
        exp_q.delete();
        ret_q.delete();
        iss();
    endtask

    task automatic release_reset();
        rst = 1'b0;
        #1;
        checks++;
        if (!mem_req || mem_we || mem_addr != RESET_PC || halted) begin
            errors++;
            $display("FAIL first_fetch got req=%0b we=%0b addr=%h halted=%0b expected 1 0 %h 0",
                     mem_req, mem_we, mem_addr, halted, RESET_PC);
        end
    endtask

    task automatic wait_halt(input string name);
        int n;
        n = 0;
        while (!halted && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!halted) begin
            errors++;
            $display("FAIL %s_halt_timeout got halted=0 expected 1 within 3000 cycles", name);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || ret_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got txn_left=%0d ret_left=%0d expected 0 0", name, exp_q.size(), ret_q.size());
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #3;
            checks++;
            if (mem_req || !halted) begin
                errors++;
                $display("FAIL %s_halt_quiet got req=%0b halted=%0b expected 0 1", name, mem_req, halted);
            end
        end
    endtask

    task automatic run_prog(input string name, input int nrst);
        assert_reset(nrst);
        release_reset();
        wait_halt(name);
    endtask

    task automatic check_word(input logic [31:0] addr, input logic [31:0] w, input string name);
        checks++;
        if (mem[addr[8:2]] !== w) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, mem[addr[8:2]], w);
        end
    endtask

    task automatic load_t1();
        clear_mem(0);
        put(32'h00, addi(5'd1, 5'd0, 32'd5));
        put(32'h04, addi(5'd2, 5'd1, -32'sd3));
        put(32'h08, enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
        put(32'h0C, enc_s(32'h100, 5'd3, 5'd0));
    endtask

    task automatic gen_random(input int n);
        logic [4:0] rd, ra, rb;
        int k;
        logic [31:0] pc;
        clear_mem(1);
        pc = 32'd0;
        for (int i = 0; i < n; i++) begin
            rd = 5'($urandom_range(0, 7));
            ra = 5'($urandom_range(0, 7));
            rb = 5'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0, 1: begin
                    k = $urandom_range(0, 4);
                    case (k)
                        0: put(pc, enc_r(7'h00, rb, ra, 3'd0, rd));
                        1: put(pc, enc_r(7'h20, rb, ra, 3'd0, rd));
                        2: put(pc, enc_r(7'h00, rb, ra, 3'd7, rd));
                        3: put(pc, enc_r(7'h00, rb, ra, 3'd6, rd));
                        default: put(pc, enc_r(7'h00, rb, ra, 3'd2, rd));
                    endcase
                end
                4: put(pc, lw(rd, 32'h100 + 4 * $urandom_range(0, 15)));
                5: put(pc, enc_s(32'h100 + 4 * $urandom_range(0, 15), rb, 5'd0));
                6: put(pc, enc_b(32'd8, rb, ra, 3'($urandom_range(0, 1))));
                7: put(pc, enc_j(32'd8, rd));
                default: put(pc, addi(rd, ra, 32'($urandom_range(0, 4095))));
            endcase
            pc += 4;
        end
        for (int i = 1; i < 8; i++) begin
            put(pc, enc_s(32'h180 + 4 * i, 5'(i), 5'd0));
            pc += 4;
        end
        put(pc, 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        clear_mem(0);
        set_waits(0, 0, 0, 0);

        load_t1();
        run_prog("t1", 2);
        check_word(32'h100, 32'd7, "t1_x3");

        clear_mem(0);
        put(32'h00, addi(5'd3, 5'd0, 32'd7));
        put(32'h04, enc_s(32'h108, 5'd3, 5'd0));
        put(32'h08, lw(5'd4, 32'h108));
        put(32'h0C, enc_s(32'h10C, 5'd4, 5'd0));
        set_waits(0, 0, 3, 3);
        run_prog("t2", 2);
        check_word(32'h10C, 32'd7, "t2_x4");
        set_waits(0, 0, 0, 0);

        clear_mem(0);
        put(32'h00, addi(5'd1, 5'd0, 32'd1));
        put(32'h04, enc_b(32'd8, 5'd1, 5'd1, 3'd0));
        put(32'h08, addi(5'd5, 5'd0, 32'd9));
        put(32'h0C, enc_b(32'd8, 5'd1, 5'd1, 3'd1));
        put(32'h10, addi(5'd6, 5'd0, 32'd2));
        put(32'h14, enc_s(32'h100, 5'd5, 5'd0));
        put(32'h18, enc_s(32'h104, 5'd6, 5'd0));
        run_prog("t3", 2);
        check_word(32'h100, 32'd0, "t3_beq_skip");
        check_word(32'h104, 32'd2, "t3_bne_fall");

        clear_mem(0);
        put(32'h00, addi(5'd0, 5'd0, 32'd1));
        put(32'h04, enc_s(32'h100, 5'd0, 5'd0));
        put(32'h08, enc_j(32'd8, 5'd0));
        put(32'h0C, enc_b(32'd12, 5'd0, 5'd0, 3'd0));
        put(32'h10, enc_j(-32'sd4, 5'd1));
        put(32'h18, enc_s(32'h104, 5'd1, 5'd0));
        put(32'h100, 32'hDEAD_BEEF);
        run_prog("t4", 2);
        check_word(32'h100, 32'd0, "t4_x0");
        check_word(32'h104, 32'h14, "t4_jal_link");

        clear_mem(0);
        run_prog("t5_illegal", 2);
        load_t1();
        run_prog("t5_recover", 1);
        check_word(32'h100, 32'd7, "t5_x3");

        clear_mem(0);
        put(32'h00, addi(5'd1, 5'd0, 32'd3));
        put(32'h04, lw(5'd2, 32'h102));
        put(32'h08, enc_s(32'h100, 5'd1, 5'd0));
        run_prog("lw_misaligned", 2);
        check_word(32'h100, 32'd0, "lw_misaligned_nostore");

        clear_mem(0);
        put(32'h00, enc_b(32'd6, 5'd0, 5'd0, 3'd0));
        run_prog("br_misaligned", 2);

        load_t1();
        set_waits(3, 3, 0, 0);
        assert_reset(2);
        release_reset();
        repeat (2) @(posedge clk);
        set_waits(0, 0, 0, 0);
        run_prog("rst_mid", 2);

        for (int t = 0; t < 6; t++) begin
            gen_random(30);
            set_waits(0, t % 3, 0, 2);
            run_prog("random", 2);
        end
        set_waits(0, 0, 0, 0);

`ifdef CPU_PERF_CNT_EN
        load_t1();
        assert_reset(2);
        release_reset();
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (perf_cycle != 64'd12 || perf_instret != 64'd3) begin
            errors++;
            $display("FAIL perf got cycle=%0d instret=%0d expected 12 3", perf_cycle, perf_instret);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (perf_cycle != 64'd0 || perf_instret != 64'd0) begin
            errors++;
            $display("FAIL perf_rst got cycle=%0d instret=%0d expected 0 0", perf_cycle, perf_instret);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        errors++;
        $display("FAIL watchdog got no completion expected finish before 600000");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

endmodule
